// File: rtl/branch_control.sv
`default_nettype none
// ============================================================================
// Module   : branch_control
// Purpose  : PC-source branch decision (combinational) with a registered copy,
//            sticky illegal-select flag and optional taken-branch counter
//            (enabled by defining BRANCH_STATS_EN).
// Revision : 1.0
// ============================================================================
module branch_control #(
    parameter int REG_BITS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          PCSrc,
    input  logic [2:0]          opcode2,
    input  logic [REG_BITS-1:0] operand,
    output logic                branch,
    output logic                branch_q,
    output logic                illegal,
    output logic [31:0]         taken_count
);

    localparam logic [1:0] c_PC_SEQ  = 2'b00;
    localparam logic [1:0] c_PC_COND = 2'b01;
    localparam logic [1:0] c_PC_POP  = 2'b10;
    localparam logic [1:0] c_PC_RSVD = 2'b11;

    localparam logic [2:0] c_BZ   = 3'b000;
    localparam logic [2:0] c_BNZ  = 3'b001;
    localparam logic [2:0] c_BLTZ = 3'b010;
    localparam logic [2:0] c_BGEZ = 3'b011;
    localparam logic [2:0] c_BGTZ = 3'b100;
    localparam logic [2:0] c_BLEZ = 3'b101;
    localparam logic [2:0] c_BAL  = 3'b110;
    localparam logic [2:0] c_BNV  = 3'b111;

    logic w_zero;
    logic w_neg;
    logic w_cond;
    logic r_branch_q;
    logic r_illegal;

    // Sign comes from the MSB alone; zero is neither negative nor positive.
    assign w_zero = (operand == '0);
    assign w_neg  = operand[REG_BITS-1];

    always_comb begin
        w_cond = 1'b0;
        case (opcode2)
            c_BZ:    w_cond = w_zero;
            c_BNZ:   w_cond = !w_zero;
            c_BLTZ:  w_cond = w_neg;
            c_BGEZ:  w_cond = !w_neg;
            c_BGTZ:  w_cond = !w_neg && !w_zero;
            c_BLEZ:  w_cond = w_neg || w_zero;
            c_BAL:   w_cond = 1'b1;
            c_BNV:   w_cond = 1'b0;
            default: w_cond = 1'b0;
        endcase
    end

    always_comb begin
        branch = 1'b0;
        case (PCSrc)
            c_PC_SEQ:  branch = 1'b0;
            c_PC_COND: branch = w_cond;
            c_PC_POP:  branch = 1'b1;
            c_PC_RSVD: branch = 1'b0;
            default:   branch = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_q <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_branch_q <= branch;
            if (PCSrc == c_PC_RSVD) begin
                r_illegal <= 1'b1;
            end
        end
    end

    assign branch_q = r_branch_q;
    assign illegal  = r_illegal;

`ifdef BRANCH_STATS_EN
    logic [31:0] r_taken_count;

    // Free-running; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_taken_count <= 32'd0;
        end else if (branch) begin
            r_taken_count <= r_taken_count + 32'd1;
        end
    end

    assign taken_count = r_taken_count;
`else
    assign taken_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_control
// Purpose  : Directed self-checking bench for branch_control.
// Revision : 1.0
// ============================================================================
module tb_branch_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  PCSrc;
    logic [2:0]  opcode2;
    logic [31:0] operand;
    logic        branch;
    logic        branch_q;
    logic        illegal;
    logic [31:0] taken_count;

    int checks = 0;
    int errors = 0;

`ifdef BRANCH_STATS_EN
    localparam bit c_STATS = 1'b1;
`else
    localparam bit c_STATS = 1'b0;
`endif

    branch_control #(.REG_BITS(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .PCSrc       (PCSrc),
        .opcode2     (opcode2),
        .operand     (operand),
        .branch      (branch),
        .branch_q    (branch_q),
        .illegal     (illegal),
        .taken_count (taken_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] pc, input logic [2:0] op, input logic [31:0] val);
        PCSrc   = pc;
        opcode2 = op;
        operand = val;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input string tag, input logic [1:0] pc, input logic [2:0] op,
                       input logic [31:0] val, input logic exp);
        drive(pc, op, val);
        chk(tag, {31'd0, branch}, {31'd0, exp});
    endtask

    initial begin
        reset = 1'b1;
        drive(2'b10, 3'b000, 32'd0);
        step();
        chk("reset_branch_q", {31'd0, branch_q}, 32'd0);
        chk("reset_illegal", {31'd0, illegal}, 32'd0);
        chk("reset_count", taken_count, 32'd0);
        chk("reset_comb_branch", {31'd0, branch}, 32'd1);

        // Three taken cycles then one not-taken.
        reset = 1'b0;
        step();
        chk("bq_after_taken", {31'd0, branch_q}, 32'd1);
        step();
        step();
        drive(2'b00, 3'b000, 32'd1);
        chk("seq_branch", {31'd0, branch}, 32'd0);
        step();
        chk("seq_branch_q", {31'd0, branch_q}, 32'd0);
        chk("count_three", taken_count, c_STATS ? 32'd3 : 32'd0);

        vec("bz_0",    2'b01, 3'b000, 32'd0, 1'b1);
        vec("bz_1",    2'b01, 3'b000, 32'd1, 1'b0);
        vec("bnz_1",   2'b01, 3'b001, 32'd1, 1'b1);
        vec("bnz_0",   2'b01, 3'b001, 32'd0, 1'b0);
        vec("bnz_5",   2'b01, 3'b001, 32'd5, 1'b1);
        vec("pop_0",   2'b10, 3'b111, 32'd0, 1'b1);
        vec("pop_1",   2'b10, 3'b000, 32'd1, 1'b1);
        vec("seq_bal", 2'b00, 3'b110, 32'd0, 1'b0);

        vec("bltz_min",  2'b01, 3'b010, 32'h8000_0000, 1'b1);
        vec("bltz_m1",   2'b01, 3'b010, 32'hFFFF_FFFF, 1'b1);
        vec("bltz_0",    2'b01, 3'b010, 32'd0,         1'b0);
        vec("bltz_1",    2'b01, 3'b010, 32'd1,         1'b0);
        vec("bgez_min",  2'b01, 3'b011, 32'h8000_0000, 1'b0);
        vec("bgez_m1",   2'b01, 3'b011, 32'hFFFF_FFFF, 1'b0);
        vec("bgez_0",    2'b01, 3'b011, 32'd0,         1'b1);
        vec("bgez_1",    2'b01, 3'b011, 32'd1,         1'b1);
        vec("bgtz_min",  2'b01, 3'b100, 32'h8000_0000, 1'b0);
        vec("bgtz_m1",   2'b01, 3'b100, 32'hFFFF_FFFF, 1'b0);
        vec("bgtz_0",    2'b01, 3'b100, 32'd0,         1'b0);
        vec("bgtz_1",    2'b01, 3'b100, 32'd1,         1'b1);
        vec("blez_min",  2'b01, 3'b101, 32'h8000_0000, 1'b1);
        vec("blez_m1",   2'b01, 3'b101, 32'hFFFF_FFFF, 1'b1);
        vec("blez_0",    2'b01, 3'b101, 32'd0,         1'b1);
        vec("blez_1",    2'b01, 3'b101, 32'd1,         1'b0);
        vec("bal",       2'b01, 3'b110, 32'd0,         1'b1);
        vec("bnv",       2'b01, 3'b111, 32'd0,         1'b0);

        // Reserved select: no branch, sticky illegal after the edge.
        vec("rsvd_branch", 2'b11, 3'b110, 32'd0, 1'b0);
        chk("illegal_pre_edge", {31'd0, illegal}, 32'd0);
        step();
        chk("illegal_set", {31'd0, illegal}, 32'd1);
        drive(2'b00, 3'b000, 32'd0);
        step();
        step();
        chk("illegal_sticky", {31'd0, illegal}, 32'd1);

        // Re-baseline the counter, then reset mid-run.
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(2'b10, 3'b000, 32'd0);
        step();
        step();
        chk("count_two", taken_count, c_STATS ? 32'd2 : 32'd0);
        chk("bq_pre_reset", {31'd0, branch_q}, 32'd1);
        reset = 1'b1;
        step();
        chk("midreset_count", taken_count, 32'd0);
        chk("midreset_branch_q", {31'd0, branch_q}, 32'd0);
        chk("midreset_illegal", {31'd0, illegal}, 32'd0);
        chk("midreset_branch", {31'd0, branch}, 32'd1);
        reset = 1'b0;
        step();
        chk("resume_count", taken_count, c_STATS ? 32'd1 : 32'd0);
        chk("resume_branch_q", {31'd0, branch_q}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_control.md
# branch_control

Branch-decision block of the single-cycle datapath. Consumes the PC-source select, the branch sub-opcode and the tested register operand, and tells the PC mux whether to leave the sequential PC (PC+4). The decision is combinational so it is usable in the same cycle. A registered copy and an optional taken-branch counter serve pipeline and debug consumers.

## Interface
- REG_BITS, 32, width of the tested operand (two's complement).
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- PCSrc  in  2  PC source: 00 = PC_temp (sequential), 01 = conditional branch, 10 = pop_pc (return), 11 = reserved.
- opcode2  in  3  branch condition code, used only when PCSrc = 01.
- operand  in  REG_BITS  register value tested by the condition.
- branch  out  1  combinational. 1 = PC mux leaves the sequential path.
- branch_q  out  1  branch registered on clk.
- illegal  out  1  registered sticky flag. Set when PCSrc = 11 is sampled.
- taken_count  out  32  count of cycles with branch = 1 (see Configuration).

## Operation
- PCSrc = 00 -> branch = 0, regardless of opcode2 and operand.
- PCSrc = 10 -> branch = 1, regardless of opcode2 and operand (unconditional return).
- PCSrc = 11 -> branch = 0. illegal is set on the next clk edge.
- PCSrc = 01 -> branch = condition(opcode2, operand). operand is signed; its sign is bit REG_BITS-1.
  - 000 BZ: operand == 0.
  - 001 BNZ: operand != 0. Any nonzero bit counts, e.g. 5 -> 1.
  - 010 BLTZ: operand < 0.
  - 011 BGEZ: operand >= 0.
  - 100 BGTZ: operand > 0.
  - 101 BLEZ: operand <= 0.
  - 110 BAL: always 1.
  - 111 BNV: always 0.
- branch has no dependence on clk or reset. It is a pure function of the current inputs.
- Boundary values:
  - Most negative value (1 followed by zeros) is < 0 and nonzero.
  - All-ones (-1) is < 0.
  - Zero is neither < 0 nor > 0.
- illegal stays 1 until reset.

## Timing
- branch: zero-cycle latency. It settles within the same cycle the inputs change.
- branch_q: one-cycle latency, equal to branch sampled at the previous rising edge.
- On a rising edge with reset = 1: branch_q = 0, illegal = 0, taken_count = 0. This overrides all other updates on that edge.
- While reset is high, branch remains combinationally valid; only the registered outputs are held at 0.
- Reset mid-operation: registered outputs clear on that edge. Counting and flagging resume on the first edge with reset = 0.
- No handshake. Inputs are assumed stable around the clk edge.

## Configuration
- BRANCH_STATS_EN defined:
  - taken_count increments by 1 on each rising edge where reset = 0 and branch = 1.
  - It wraps from 0xFFFFFFFF to 0.
- BRANCH_STATS_EN undefined:
  - taken_count is constantly 0 and no counter register is built.
  - All other behaviour is identical.

## Test plan
- PCSrc=00, opcode2=000, operand=1 -> branch=0. Next edge: branch_q=0.
- PCSrc=01, opcode2=000 -> operand=0 gives branch=1; operand=1 gives branch=0.
- PCSrc=01, opcode2=001 -> operand=1 gives branch=1; operand=0 gives 0; operand=5 gives 1.
- PCSrc=10 with operand=0 or 1 -> branch=1. PCSrc=11 -> branch=0, and illegal=1 after the edge until reset.
- Signed conditions with operand=0x80000000, 0xFFFFFFFF, 0, 1:
  - BLTZ -> 1,1,0,0
  - BGEZ -> 0,0,1,1
  - BGTZ -> 0,0,0,1
  - BLEZ -> 1,1,1,0
- With BRANCH_STATS_EN, after reset:
  - Three taken cycles followed by one not-taken cycle -> taken_count=3.
  - Asserting reset mid-run -> taken_count=0 and branch_q=0 on that edge.
